// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall / branch+jump flush sequencer for the ID/EX stage.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state;
  logic [1:0] bub_cnt;
  logic uses_rt, lu_haz, jmp, stall_ev, flush_ev;
  always_comb begin
    uses_rt = id_opcode inside {6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b101011, 6'b000101};
    lu_haz = ex_mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
    jmp = id_opcode == 6'b100000;
    stall_ev = !reset && !ex_br_taken && (state == STALL || lu_haz);
    flush_ev = !reset && (ex_br_taken || (state == RUN && !lu_haz && jmp));
    pc_write = !reset && !stall_ev;
    ifid_write = !reset && !stall_ev;
    ifid_flush = reset || flush_ev;
    idex_bubble = reset || ex_br_taken || stall_ev;
  end
  always_ff @(posedge clk) begin
    if (reset || ex_br_taken) begin
      state <= RUN;
      bub_cnt <= 2'd0;
    end else if (state == STALL) begin
      bub_cnt <= bub_cnt - 2'd1;
      state <= bub_cnt == 2'd1 ? RUN : STALL;
    end else if (lu_haz && LOAD_BUBBLES > 1) begin
      state <= STALL;
      bub_cnt <= 2'(LOAD_BUBBLES - 1);
    end
  end
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] s_q, f_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
      f_q <= '0;
    end else begin
      if (stall_ev && !(&s_q)) s_q <= s_q + CNT_W'(1);
      if (flush_ev && !(&f_q)) f_q <= f_q + CNT_W'(1);
    end
  end
  assign stall_cnt = s_q;
  assign flush_cnt = f_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table vectors plus random traffic against a remaining-bubble model, LOAD_BUBBLES=3 and =1.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0, reset, ex_mem_read, ex_br_taken;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc3, wr3, fl3, bub3, pc1, wr1, fl1, bub1;
  logic [15:0] sc3, fc3;
  logic [3:0] sc1, fc1;
  int total = 0, bad = 0;
  int rem[2] = '{0, 0};
  int sc[2] = '{0, 0};
  int fc[2] = '{0, 0};
  int lb[2] = '{3, 1};
  int mx[2] = '{65535, 15};
`ifdef HAZ_PERF_CNT_EN
  bit cnt_en = 1'b1;
`else
  bit cnt_en = 1'b0;
`endif
  typedef struct {
    logic rst; logic [5:0] op; logic [4:0] rs, rt; logic mr; logic [4:0] ert; logic br; logic [3:0] e;
  } vec_t;
  vec_t tab[20];
  logic [5:0] ops[7] = '{6'b000000, 6'b000011, 6'b101011, 6'b000101, 6'b100011, 6'b100000, 6'b001000};

  hazard_stall_ctrl #(.LOAD_BUBBLES(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .pc_write(pc3), .ifid_write(wr3), .ifid_flush(fl3), .idex_bubble(bub3),
    .stall_cnt(sc3), .flush_cnt(fc3));
  hazard_stall_ctrl #(.LOAD_BUBBLES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .pc_write(pc1), .ifid_write(wr1), .ifid_flush(fl1), .idex_bubble(bub1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  always #5 clk = ~clk;

  function automatic bit haz();
    bit urt = id_opcode inside {6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b101011, 6'b000101};
    return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (urt && ex_rt == id_rt));
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tab);
    @(negedge clk);
    reset = v.rst; id_opcode = v.op; id_rs = v.rs; id_rt = v.rt;
    ex_mem_read = v.mr; ex_rt = v.ert; ex_br_taken = v.br;
    #2;
    if (use_tab) check("table_outs_lb3", {pc3, wr3, fl3, bub3}, v.e);
    for (int m = 0; m < 2; m++) begin
      logic [3:0] e;
      bit h = haz(), j = id_opcode == 6'b100000;
      e = reset ? 4'b0011 : ex_br_taken ? 4'b1111 : (rem[m] > 0 || h) ? 4'b0001 : j ? 4'b1110 : 4'b1100;
      check(m == 0 ? "outs_lb3" : "outs_lb1", m == 0 ? {pc3, wr3, fl3, bub3} : {pc1, wr1, fl1, bub1}, e);
      check(m == 0 ? "stall_cnt_lb3" : "stall_cnt_lb1", m == 0 ? int'(sc3) : int'(sc1), cnt_en ? sc[m] : 0);
      check(m == 0 ? "flush_cnt_lb3" : "flush_cnt_lb1", m == 0 ? int'(fc3) : int'(fc1), cnt_en ? fc[m] : 0);
      if (reset) begin
        rem[m] = 0; sc[m] = 0; fc[m] = 0;
      end else if (ex_br_taken) begin
        rem[m] = 0; fc[m] = fc[m] < mx[m] ? fc[m] + 1 : fc[m];
      end else if (rem[m] > 0 || h) begin
        rem[m] = rem[m] > 0 ? rem[m] - 1 : lb[m] - 1;
        sc[m] = sc[m] < mx[m] ? sc[m] + 1 : sc[m];
      end else if (j) fc[m] = fc[m] < mx[m] ? fc[m] + 1 : fc[m];
    end
  endtask

  initial begin
    vec_t v;
    tab[0]  = '{1'b1, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0011};
    tab[1]  = '{1'b0, 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 4'b1100};
    tab[2]  = '{1'b0, 6'b000000, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 4'b0001};
    tab[3]  = '{1'b0, 6'b000000, 5'd5, 5'd2, 1'b0, 5'd0, 1'b0, 4'b0001};
    tab[4]  = '{1'b0, 6'b000000, 5'd5, 5'd2, 1'b0, 5'd0, 1'b0, 4'b0001};
    tab[5]  = '{1'b0, 6'b000000, 5'd5, 5'd2, 1'b0, 5'd0, 1'b0, 4'b1100};
    tab[6]  = '{1'b0, 6'b000000, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 4'b1100};
    tab[7]  = '{1'b0, 6'b100011, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 4'b1100};
    tab[8]  = '{1'b0, 6'b101011, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 4'b0001};
    tab[9]  = '{1'b0, 6'b101011, 5'd1, 5'd7, 1'b0, 5'd0, 1'b1, 4'b1111};
    tab[10] = '{1'b0, 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 4'b1100};
    tab[11] = '{1'b0, 6'b100000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 4'b1110};
    tab[12] = '{1'b0, 6'b100000, 5'd3, 5'd2, 1'b1, 5'd3, 1'b0, 4'b0001};
    tab[13] = '{1'b0, 6'b100000, 5'd3, 5'd2, 1'b0, 5'd0, 1'b0, 4'b0001};
    tab[14] = '{1'b0, 6'b100000, 5'd3, 5'd2, 1'b0, 5'd0, 1'b0, 4'b0001};
    tab[15] = '{1'b0, 6'b100000, 5'd3, 5'd2, 1'b0, 5'd0, 1'b0, 4'b1110};
    tab[16] = '{1'b0, 6'b000000, 5'd1, 5'd4, 1'b1, 5'd4, 1'b0, 4'b0001};
    tab[17] = '{1'b1, 6'b000000, 5'd1, 5'd4, 1'b0, 5'd0, 1'b0, 4'b0011};
    tab[18] = '{1'b0, 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 4'b1100};
    tab[19] = '{1'b0, 6'b001000, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 4'b1100};
    reset = 1'b1; id_opcode = '0; id_rs = '0; id_rt = '0;
    ex_mem_read = 1'b0; ex_rt = '0; ex_br_taken = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++) step(tab[i], 1'b1);
    for (int i = 0; i < 800; i++) begin
      v.rst = $urandom_range(0, 299) == 0;
      v.op = ops[$urandom_range(0, 6)];
      v.rs = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.mr = 1'($urandom_range(0, 1));
      v.ert = 5'($urandom_range(0, 3));
      v.br = $urandom_range(0, 7) == 0;
      v.e = 4'b0;
      step(v, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
